fpga_rst_seq: RTL and testbench

Board-level reset sequencer between the PLL/board-reset logic and the Ara SoC and APB UART, replacing the two-flop lock-to-reset path.
- Synchronises and filters PLL lock, enforces a minimum reset hold time, and releases the peripheral (UART) reset before the SoC reset.
- Handles PLL lock loss and supports a SoC-only soft reset.

---
 rtl/fpga_rst_seq_if.sv | 31 +++
 rtl/fpga_rst_seq.sv | 141 ++++++++++++++
 tb/tb_fpga_rst_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fpga_rst_seq_if.sv
// Reset sequencer board-side bundle: PLL lock and soft request in, reset lines and status out.
// Latency: none, this file only groups the wires.
// Backpressure: none; all signals are level-based.
interface fpga_rst_seq_if;
  logic       pll_locked_i;
  logic       soft_rst_req_i;
  logic       periph_rst_no;
  logic       soc_rst_no;
  logic [2:0] rst_state_o;
  logic       lock_lost_o;

  // Board/PLL side that drives lock and soft request and observes the resets
  modport master (
    output pll_locked_i,
    output soft_rst_req_i,
    input  periph_rst_no,
    input  soc_rst_no,
    input  rst_state_o,
    input  lock_lost_o
  );

  // Sequencer side
  modport slave (
    input  pll_locked_i,
    input  soft_rst_req_i,
    output periph_rst_no,
    output soc_rst_no,
    output rst_state_o,
    output lock_lost_o
  );
endinterface

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: filters PLL lock, holds resets, then releases peripherals before the SoC.
// Latency: periph release SyncStages+LockFilterCycles+HoldCycles edges after release, SoC StaggerCycles later.
// Backpressure: none; lock loss forces both resets low, a soft request re-resets only the SoC.
module fpga_rst_seq #(
  parameter int LockFilterCycles = 1024,
  parameter int HoldCycles       = 256,
  parameter int StaggerCycles    = 16,
  parameter int SyncStages       = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fpga_rst_seq_if.slave bus
);

  // Parameter legality is checked at elaboration so a bad build never reaches hardware
  if (LockFilterCycles < 1) begin : g_bad_lock_filter
    $error("LockFilterCycles must be >= 1");
  end
  if (HoldCycles < 1) begin : g_bad_hold
    $error("HoldCycles must be >= 1");
  end
  if (StaggerCycles < 1) begin : g_bad_stagger
    $error("StaggerCycles must be >= 1");
  end
  if (SyncStages < 2) begin : g_bad_sync
    $error("SyncStages must be >= 2");
  end

  localparam int MaxLh  = (LockFilterCycles > HoldCycles) ? LockFilterCycles : HoldCycles;
  localparam int MaxCyc = (MaxLh > StaggerCycles) ? MaxLh : StaggerCycles;
  localparam int CntW   = $clog2(MaxCyc) + 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t LockLast    = cnt_t'(LockFilterCycles - 1);
  localparam cnt_t HoldLast    = cnt_t'(HoldCycles - 1);
  localparam cnt_t StaggerLast = cnt_t'(StaggerCycles - 1);

  typedef enum logic [2:0] {
    WaitLock = 3'd0,
    Hold     = 3'd1,
    PeriphUp = 3'd2,
    Run      = 3'd3
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  lock_s;
  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  periph_rst_nq, periph_rst_nd;
  logic                  soc_rst_nq, soc_rst_nd;

  // Bring the asynchronous PLL lock into the clock domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], bus.pll_locked_i};
    end
  end

  assign lock_s = sync_q[SyncStages-1];

  // Next-state, shared counter and output decode; counter clears on every transition
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + cnt_t'(1);
    lock_lost_d = lock_lost_q;
    unique case (state_q)
      WaitLock: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = Hold;
          cnt_d   = '0;
        end
      end
      Hold: begin
        if (!lock_s) begin
          state_d = WaitLock;
          cnt_d   = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = PeriphUp;
          cnt_d   = '0;
        end
      end
      PeriphUp: begin
        if (!lock_s) begin
          state_d = WaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StaggerLast) begin
          state_d = Run;
          cnt_d   = '0;
        end
      end
      Run: begin
        // Lock loss outranks a simultaneous soft request
        if (!lock_s) begin
          state_d     = WaitLock;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (bus.soft_rst_req_i) begin
          state_d = PeriphUp;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = WaitLock;
        cnt_d   = '0;
      end
    endcase
    periph_rst_nd = (state_d == PeriphUp) || (state_d == Run);
    soc_rst_nd    = (state_d == Run);
  end

  // State, counter and registered reset outputs all update on the same edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= WaitLock;
      cnt_q         <= '0;
      lock_lost_q   <= 1'b0;
      periph_rst_nq <= 1'b0;
      soc_rst_nq    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_lost_q   <= lock_lost_d;
      periph_rst_nq <= periph_rst_nd;
      soc_rst_nq    <= soc_rst_nd;
    end
  end

  assign bus.periph_rst_no = periph_rst_nq;
  assign bus.soc_rst_no    = soc_rst_nq;
  assign bus.rst_state_o   = state_q;
  assign bus.lock_lost_o   = lock_lost_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Bench for fpga_rst_seq with small parameters (4/8/2/2).
// Stimulus queues expected output transitions tagged with the clock edge they must follow.
// A monitor compares every observed output change against the head of that queue.
module tb_fpga_rst_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fpga_rst_seq_if bus_if ();

  fpga_rst_seq #(
    .LockFilterCycles(4),
    .HoldCycles      (8),
    .StaggerCycles   (2),
    .SyncStages      (2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    int         c;
    logic [2:0] st;
    logic       p;
    logic       s;
    logic       l;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_at(input int c, input logic [2:0] st, input logic p, input logic s,
                           input logic l);
    exp_t e;
    e.c  = c;
    e.st = st;
    e.p  = p;
    e.s  = s;
    e.l  = l;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_now({tag, "_periph"}, {2'b00, bus_if.periph_rst_no}, 3'd0);
    check_now({tag, "_soc"}, {2'b00, bus_if.soc_rst_no}, 3'd0);
    check_now({tag, "_state"}, bus_if.rst_state_o, 3'd0);
    check_now({tag, "_lock_lost"}, {2'b00, bus_if.lock_lost_o}, 3'd0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every change of {state, periph, soc, lock_lost} must match the queue head
  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    logic [5:0] want;
    exp_t       e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {bus_if.rst_state_o, bus_if.periph_rst_no, bus_if.soc_rst_no, bus_if.lock_lost_o};
      if (rst_n === 1'b1) begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
          checks++;
          failures++;
          $display("FAIL missed_transition: state=%0d due after edge %0d, not seen by edge %0d",
                   exp_q[0].st, exp_q[0].c, cyc);
          void'(exp_q.pop_front());
        end
        if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_transition: edge %0d st/p/s/l=%b none expected", cyc, cur);
          end else begin
            e    = exp_q.pop_front();
            want = {e.st, e.p, e.s, e.l};
            if (cur !== want || cyc != e.c) begin
              failures++;
              $display("FAIL transition: got st/p/s/l=%b at edge %0d, required %b at edge %0d",
                       cur, cyc, want, e.c);
            end
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int b;
    int c;
    int d;
    int e;
    bus_if.pll_locked_i   = 1'b1;
    bus_if.soft_rst_req_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("por");

    // Nominal power-up with lock stable high
    repeat (3) @(negedge clk);
    b = cyc;
    rst_n = 1'b1;
    expect_at(b + 6, 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(b + 14, 3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(b + 16, 3'd3, 1'b1, 1'b1, 1'b0);
    wait_until(b + 20);

    // Soft reset in RUN: SoC reset low for two cycles, peripherals stay up
    c = cyc;
    bus_if.soft_rst_req_i = 1'b1;
    expect_at(c + 1, 3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(c + 3, 3'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus_if.soft_rst_req_i = 1'b0;
    wait_until(c + 6);

    // Lock loss in RUN for 5 cycles, full resequence; soft pulse in HOLD ignored
    d = cyc;
    bus_if.pll_locked_i = 1'b0;
    expect_at(d + 3, 3'd0, 1'b0, 1'b0, 1'b1);
    expect_at(d + 11, 3'd1, 1'b0, 1'b0, 1'b1);
    expect_at(d + 19, 3'd2, 1'b1, 1'b0, 1'b1);
    expect_at(d + 21, 3'd3, 1'b1, 1'b1, 1'b1);
    wait_until(d + 5);
    bus_if.pll_locked_i = 1'b1;
    wait_until(d + 13);
    bus_if.soft_rst_req_i = 1'b1;
    @(negedge clk);
    bus_if.soft_rst_req_i = 1'b0;
    wait_until(d + 25);

    // Soft request on the same edge the FSM sees lock loss: lock loss wins
    e = cyc;
    bus_if.pll_locked_i = 1'b0;
    expect_at(e + 3, 3'd0, 1'b0, 1'b0, 1'b1);
    expect_at(e + 11, 3'd1, 1'b0, 1'b0, 1'b1);
    expect_at(e + 19, 3'd2, 1'b1, 1'b0, 1'b1);
    wait_until(e + 2);
    bus_if.soft_rst_req_i = 1'b1;
    @(negedge clk);
    bus_if.soft_rst_req_i = 1'b0;
    wait_until(e + 5);
    bus_if.pll_locked_i = 1'b1;

    // Asynchronous reset mid-cycle while in PERIPH_UP
    wait_until(e + 19);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    repeat (2) @(negedge clk);

    // Restart with a one-cycle lock glitch after three filtered cycles
    b = cyc;
    rst_n = 1'b1;
    expect_at(b + 10, 3'd1, 1'b0, 1'b0, 1'b0);
    expect_at(b + 18, 3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(b + 20, 3'd3, 1'b1, 1'b1, 1'b0);
    wait_until(b + 3);
    bus_if.pll_locked_i = 1'b0;
    @(negedge clk);
    bus_if.pll_locked_i = 1'b1;
    wait_until(b + 24);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations: %0d left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
